// File: rtl/alarm_clock_fsm.sv
// Moore sequencer for the alarm-clock datapath: turns keypad/button activity into
// shift/load strobes and LCD source selects, with a keypad-inactivity timeout.
module alarm_clock_fsm #(
  parameter logic [3:0] NOKEY       = 4'd10,
  parameter int         TIMEOUT_SEC = 10,
  parameter int         CNT_W       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_a,
  output logic       show_new_time
);

  typedef enum logic [2:0] {
    SHOW_TIME,
    KEY_STORED,
    KEY_WAITED,
    KEY_ENTRY,
    SHOW_ALARM,
    SET_ALARM_TIME,
    SET_CURRENT_TIME
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_SEC - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_counting;
  logic             w_timeout;
  logic             w_key_pressed;

  assign w_key_pressed = (key != NOKEY);
  assign w_counting    = (r_state == KEY_WAITED) || (r_state == KEY_ENTRY);
  assign w_timeout     = w_counting && one_second && (r_cnt == CNT_MAX);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      SHOW_TIME: begin
        if (alarm_button)       w_next = SHOW_ALARM;
        else if (w_key_pressed) w_next = KEY_STORED;
      end
      KEY_STORED: w_next = KEY_WAITED;
      KEY_WAITED: begin
        if (w_timeout)           w_next = SHOW_TIME;
        else if (!w_key_pressed) w_next = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        if (w_timeout)          w_next = SHOW_TIME;
        else if (alarm_button)  w_next = SET_ALARM_TIME;
        else if (time_button)   w_next = SET_CURRENT_TIME;
        else if (w_key_pressed) w_next = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!alarm_button) w_next = SHOW_TIME;
      end
      SET_ALARM_TIME:   w_next = SHOW_TIME;
      SET_CURRENT_TIME: w_next = SHOW_TIME;
      default:          w_next = SHOW_TIME;
    endcase
  end

  // A new key (entry to KEY_STORED) or a timeout restarts the inactivity window.
  always_comb begin
    w_cnt_next = '0;
    if (w_counting && !w_timeout && (w_next != KEY_STORED))
      w_cnt_next = one_second ? r_cnt + 1'b1 : r_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= SHOW_TIME;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift         <= 1'b0;
      load_new_a    <= 1'b0;
      load_new_c    <= 1'b0;
      show_a        <= 1'b0;
      show_new_time <= 1'b0;
    end else begin
      shift         <= (w_next == KEY_STORED);
      load_new_a    <= (w_next == SET_ALARM_TIME);
      load_new_c    <= (w_next == SET_CURRENT_TIME);
      show_a        <= (w_next == SHOW_ALARM);
      show_new_time <= (w_next == KEY_STORED) || (w_next == KEY_WAITED) ||
                       (w_next == KEY_ENTRY);
    end
  end

endmodule

// File: tb/tb_alarm_clock_fsm.sv
// Directed self-checking bench for alarm_clock_fsm: entry, loads, alarm display,
// timeout, held key and mid-entry reset.
module tb_alarm_clock_fsm;

  localparam logic [3:0] NOKEY = 4'd10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic [3:0] key = NOKEY;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic       shift, load_new_a, load_new_c, show_a, show_new_time;

  int n_checks = 0;
  int n_errors = 0;
  int n_shift, n_la, n_lc, n_sa, n_snt;

  alarm_clock_fsm dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .key          (key),
    .alarm_button (alarm_button),
    .time_button  (time_button),
    .shift        (shift),
    .load_new_a   (load_new_a),
    .load_new_c   (load_new_c),
    .show_a       (show_a),
    .show_new_time(show_new_time)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {27'd0, shift, load_new_a, load_new_c, show_a, show_new_time};
  endfunction

  task automatic clr_counts();
    n_shift = 0; n_la = 0; n_lc = 0; n_sa = 0; n_snt = 0;
  endtask

  // One clock: inputs set before the edge, outputs sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clock);
    #1;
    n_shift += int'(shift);
    n_la    += int'(load_new_a);
    n_lc    += int'(load_new_c);
    n_sa    += int'(show_a);
    n_snt   += int'(show_new_time);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic press(input logic [3:0] d);
    key = d;
    run(3);
    key = NOKEY;
    run(2);
  endtask

  task automatic pulse();
    one_second = 1'b1;
    cyc();
    one_second = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    clr_counts();
    // Reset and idle
    repeat (2) @(posedge clock);
    #1;
    check("reset_outs", outs(), 0);
    reset = 1'b1;
    run(10);
    check("idle_outs", outs(), 0);
    check("idle_shifts", n_shift, 0);
    check("idle_snt", n_snt, 0);

    // Four digits then alarm load
    clr_counts();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("entry_shifts", n_shift, 4);
    check("entry_snt_before_load", show_new_time, 1);
    alarm_button = 1'b1;
    cyc();
    check("load_a_pulse", outs(), 32'b01000);
    alarm_button = 1'b0;
    cyc();
    check("after_load_a", outs(), 0);
    run(3);
    check("entry_snt_cycles", n_snt, 20);
    check("entry_load_a_count", n_la, 1);
    check("entry_load_c_count", n_lc, 0);

    // Four digits then current-time load
    clr_counts();
    press(4'd0); press(4'd9); press(4'd5); press(4'd8);
    time_button = 1'b1;
    cyc();
    check("load_c_pulse", outs(), 32'b00100);
    time_button = 1'b0;
    run(3);
    check("after_load_c", outs(), 0);
    check("time_shifts", n_shift, 4);
    check("time_load_a_count", n_la, 0);
    check("time_load_c_count", n_lc, 1);

    // Both buttons together: alarm wins
    clr_counts();
    press(4'd6);
    alarm_button = 1'b1; time_button = 1'b1;
    cyc();
    check("both_btn_outs", outs(), 32'b01000);
    alarm_button = 1'b0; time_button = 1'b0;
    run(2);
    check("both_btn_load_c", n_lc, 0);
    check("both_btn_after", outs(), 0);

    // Show alarm while a key is held
    clr_counts();
    alarm_button = 1'b1; key = 4'd7;
    run(20);
    check("show_a_cycles", n_sa, 20);
    check("show_a_held", show_a, 1);
    check("show_a_no_shift", n_shift, 0);
    alarm_button = 1'b0; key = NOKEY;
    cyc();
    check("show_a_release", outs(), 0);
    run(3);
    check("show_a_idle", outs(), 0);

    // Timeout after one digit
    clr_counts();
    press(4'd2);
    repeat (9) pulse();
    check("to_9_pulses_entry", outs(), 32'b00001);
    pulse();
    check("to_10th_pulse", outs(), 0);
    check("to_no_load", n_la + n_lc, 0);

    // New digit after pulse 9 restarts the window
    clr_counts();
    press(4'd3);
    repeat (9) pulse();
    press(4'd4);
    repeat (9) pulse();
    check("to_restart_9", show_new_time, 1);
    pulse();
    check("to_restart_10", outs(), 0);
    check("to_restart_shifts", n_shift, 2);

    // Held key produces one shift
    clr_counts();
    key = 4'd5;
    run(50);
    check("held_shifts", n_shift, 1);
    check("held_waited", outs(), 32'b00001);
    key = NOKEY;
    cyc();
    check("held_released", outs(), 32'b00001);
    time_button = 1'b1;
    cyc();
    check("held_load_c", load_new_c, 1);
    time_button = 1'b0;
    cyc();

    // Code 11 counts as a key press
    clr_counts();
    press(4'd11);
    check("code11_shift", n_shift, 1);
    alarm_button = 1'b1;
    cyc();
    alarm_button = 1'b0;
    cyc();
    check("code11_exit", outs(), 0);

    // Asynchronous reset mid-entry with count at 5
    clr_counts();
    press(4'd8);
    repeat (5) pulse();
    check("pre_reset_entry", show_new_time, 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("async_reset_outs", outs(), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    clr_counts();
    run(10);
    check("post_reset_idle", outs(), 0);
    check("post_reset_no_strobes", n_shift + n_la + n_lc, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
